// File: rtl/buart_fifo_if.sv
// Host-side bus of buart_fifo: divisor load, TX/RX FIFO access
// and sticky error flags.
interface buart_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
);
    logic                 div_wr;
    logic [15:0]          div_in;
    logic                 tx_wr;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_full;
    logic                 tx_idle;
    logic [LW-1:0]        tx_level;
    logic                 rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [LW-1:0]        rx_level;
    logic                 err_clr;
    logic                 rx_overrun;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport master (
        output div_wr, div_in, tx_wr, tx_data,
        output rx_rd, err_clr,
        input  tx_full, tx_idle, tx_level,
        input  rx_data, rx_valid, rx_level,
        input  rx_overrun, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  div_wr, div_in, tx_wr, tx_data,
        input  rx_rd, err_clr,
        output tx_full, tx_idle, tx_level,
        output rx_data, rx_valid, rx_level,
        output rx_overrun, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/buart_fifo.sv
// Full-duplex UART with programmable divisor, optional parity
// and TX/RX FIFOs between host logic and the serial pins.
module buart_fifo #(
    parameter int CLKFREQ    = 125000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic clk,
    input  logic resetq,
    input  logic rx,
    output logic tx,
    buart_fifo_if.slave bus
);
    localparam int PW = LW - 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [15:0] DIV_RST = 16'(CLKFREQ / BAUD);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_st_e;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK
    } rx_st_e;

    logic [15:0] div_q, div_d;

    logic [DATA_BITS-1:0] txm [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_head;
    logic [PW-1:0] txw_q, txw_d, txr_q, txr_d;
    logic [LW-1:0] txl_q, txl_d;
    logic tx_push, tx_pop, tx_load, t_end;

    tx_st_e ts_q, ts_d;
    logic [15:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d;
    logic [BW-1:0] tbit_q, tbit_d;
    logic [DATA_BITS-1:0] tsh_q, tsh_d;
    logic tpar_q, tpar_d, tx_q, tx_d;

    logic rs1_q, rs2_q, rprev_q, fall;
    rx_st_e rs_q, rs_d;
    logic [15:0] rcnt_q, rcnt_d, rdiv_q, rdiv_d;
    logic [BW-1:0] rbit_q, rbit_d;
    logic [DATA_BITS-1:0] rsh_q, rsh_d;
    logic rpb_q, rpb_d, r_end, r_mid;
    logic rx_push, fe_set, pe_set;

    logic [DATA_BITS-1:0] rxm [FIFO_DEPTH];
    logic [PW-1:0] rxw_q, rxw_d, rxr_q, rxr_d;
    logic [LW-1:0] rxl_q, rxl_d;
    logic rx_pop, rx_full, rx_acc, ov_set;
    logic ov_q, ov_d, fe_q, fe_d, pe_q, pe_d;

    always_comb begin
        div_d = div_q;
        if (bus.div_wr) begin
            div_d = (bus.div_in < 16'd4) ? 16'd4 : bus.div_in;
        end
    end

    assign tx_push = bus.tx_wr && (txl_q != FULL);
    assign tx_head = txm[txr_q];

    always_comb begin
        txw_d = txw_q + PW'(tx_push);
        txr_d = txr_q + PW'(tx_pop);
        txl_d = txl_q + LW'(tx_push) - LW'(tx_pop);
    end

    always_ff @(posedge clk) begin
        if (tx_push) txm[txw_q] <= bus.tx_data;
    end

    assign t_end = (tcnt_q == tdiv_q - 16'd1);

    always_comb begin
        ts_d    = ts_q;
        tcnt_d  = tcnt_q + 16'd1;
        tdiv_d  = tdiv_q;
        tbit_d  = tbit_q;
        tsh_d   = tsh_q;
        tpar_d  = tpar_q;
        tx_d    = tx_q;
        tx_pop  = 1'b0;
        tx_load = 1'b0;
        unique case (ts_q)
            T_IDLE: begin
                tcnt_d  = '0;
                tx_load = (txl_q != '0);
            end
            T_START: if (t_end) begin
                ts_d   = T_DATA;
                tcnt_d = '0;
                tbit_d = '0;
                tx_d   = tsh_q[0];
            end
            T_DATA: if (t_end) begin
                tcnt_d = '0;
                if (tbit_q == LAST) begin
                    if (PARITY != 0) begin
                        ts_d = T_PAR;
                        tx_d = tpar_q;
                    end else begin
                        ts_d = T_STOP;
                        tx_d = 1'b1;
                    end
                end else begin
                    tbit_d = tbit_q + BW'(1);
                    tsh_d  = tsh_q >> 1;
                    tx_d   = tsh_q[1];
                end
            end
            T_PAR: if (t_end) begin
                ts_d   = T_STOP;
                tcnt_d = '0;
                tx_d   = 1'b1;
            end
            T_STOP: if (t_end) begin
                ts_d    = T_IDLE;
                tcnt_d  = '0;
                tx_d    = 1'b1;
                tx_load = (txl_q != '0);
            end
            default: ts_d = T_IDLE;
        endcase
        // Popping straight out of STOP gives back-to-back frames.
        if (tx_load) begin
            tx_pop = 1'b1;
            ts_d   = T_START;
            tcnt_d = '0;
            tdiv_d = div_q;
            tsh_d  = tx_head;
            tpar_d = (^tx_head) ^ ODD;
            tx_d   = 1'b0;
        end
    end

    assign fall  = rprev_q && !rs2_q;
    assign r_end = (rcnt_q == rdiv_q - 16'd1);
    assign r_mid = (rcnt_q == (rdiv_q >> 1) - 16'd1);

    always_comb begin
        rs_d    = rs_q;
        rcnt_d  = rcnt_q + 16'd1;
        rdiv_d  = rdiv_q;
        rbit_d  = rbit_q;
        rsh_d   = rsh_q;
        rpb_d   = rpb_q;
        rx_push = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        unique case (rs_q)
            R_IDLE: begin
                rcnt_d = '0;
                if (fall) begin
                    rs_d   = R_START;
                    rdiv_d = div_q;
                end
            end
            R_START: if (r_mid) begin
                rcnt_d = '0;
                rbit_d = '0;
                rs_d   = rs2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (r_end) begin
                rcnt_d = '0;
                rsh_d  = {rs2_q, rsh_q[DATA_BITS-1:1]};
                if (rbit_q == LAST) begin
                    rs_d = (PARITY != 0) ? R_PAR : R_STOP;
                end else begin
                    rbit_d = rbit_q + BW'(1);
                end
            end
            R_PAR: if (r_end) begin
                rcnt_d = '0;
                rpb_d  = rs2_q;
                rs_d   = R_STOP;
            end
            R_STOP: if (r_end) begin
                rcnt_d = '0;
                rs_d   = R_IDLE;
                if (!rs2_q) begin
                    fe_set = 1'b1;
                    rs_d   = R_BREAK;
                end else if (PARITY != 0 &&
                             rpb_q != ((^rsh_q) ^ ODD)) begin
                    pe_set = 1'b1;
                end else begin
                    rx_push = 1'b1;
                end
            end
            R_BREAK: begin
                rcnt_d = '0;
                if (rs2_q) rs_d = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    assign rx_pop  = bus.rx_rd && (rxl_q != '0);
    assign rx_full = (rxl_q == FULL);
    // A pop in the same cycle frees the slot the push needs.
    assign rx_acc  = rx_push && (!rx_full || rx_pop);
    assign ov_set  = rx_push && rx_full && !rx_pop;

    always_comb begin
        rxw_d = rxw_q + PW'(rx_acc);
        rxr_d = rxr_q + PW'(rx_pop);
        rxl_d = rxl_q + LW'(rx_acc) - LW'(rx_pop);
        ov_d  = (ov_q && !bus.err_clr) || ov_set;
        fe_d  = (fe_q && !bus.err_clr) || fe_set;
        pe_d  = (pe_q && !bus.err_clr) || pe_set;
    end

    always_ff @(posedge clk) begin
        if (rx_acc) rxm[rxw_q] <= rsh_q;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            div_q   <= DIV_RST;
            txw_q   <= '0;
            txr_q   <= '0;
            txl_q   <= '0;
            ts_q    <= T_IDLE;
            tcnt_q  <= '0;
            tdiv_q  <= DIV_RST;
            tbit_q  <= '0;
            tsh_q   <= '0;
            tpar_q  <= 1'b0;
            tx_q    <= 1'b1;
            rs1_q   <= 1'b1;
            rs2_q   <= 1'b1;
            rprev_q <= 1'b1;
            rs_q    <= R_IDLE;
            rcnt_q  <= '0;
            rdiv_q  <= DIV_RST;
            rbit_q  <= '0;
            rsh_q   <= '0;
            rpb_q   <= 1'b0;
            rxw_q   <= '0;
            rxr_q   <= '0;
            rxl_q   <= '0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            txw_q   <= txw_d;
            txr_q   <= txr_d;
            txl_q   <= txl_d;
            ts_q    <= ts_d;
            tcnt_q  <= tcnt_d;
            tdiv_q  <= tdiv_d;
            tbit_q  <= tbit_d;
            tsh_q   <= tsh_d;
            tpar_q  <= tpar_d;
            tx_q    <= tx_d;
            rs1_q   <= rx;
            rs2_q   <= rs1_q;
            rprev_q <= rs2_q;
            rs_q    <= rs_d;
            rcnt_q  <= rcnt_d;
            rdiv_q  <= rdiv_d;
            rbit_q  <= rbit_d;
            rsh_q   <= rsh_d;
            rpb_q   <= rpb_d;
            rxw_q   <= rxw_d;
            rxr_q   <= rxr_d;
            rxl_q   <= rxl_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end
    end

    assign tx                = tx_q;
    assign bus.tx_full       = (txl_q == FULL);
    assign bus.tx_idle       = (ts_q == T_IDLE) && (txl_q == '0);
    assign bus.tx_level      = txl_q;
    assign bus.rx_data       = rxm[rxr_q];
    assign bus.rx_valid      = (rxl_q != '0);
    assign bus.rx_level      = rxl_q;
    assign bus.rx_overrun    = ov_q;
    assign bus.rx_frame_err  = fe_q;
    assign bus.rx_parity_err = pe_q;
endmodule
